// File: rtl/placar_pkg.sv
// Shared types and constants for the two-team scoreboard: shot FSM states,
// active-low 7-segment patterns ({g,f,e,d,c,b,a}), digit indices and a bin->BCD helper.
package placar_pkg;

    typedef enum logic [1:0] {
        StPause   = 2'd0,
        StRun     = 2'd1,
        StExpired = 2'd2
    } shot_state_e;

    localparam logic [6:0] Seg0     = 7'h40;
    localparam logic [6:0] Seg1     = 7'h79;
    localparam logic [6:0] Seg2     = 7'h24;
    localparam logic [6:0] Seg3     = 7'h30;
    localparam logic [6:0] Seg4     = 7'h19;
    localparam logic [6:0] Seg5     = 7'h12;
    localparam logic [6:0] Seg6     = 7'h02;
    localparam logic [6:0] Seg7     = 7'h78;
    localparam logic [6:0] Seg8     = 7'h00;
    localparam logic [6:0] Seg9     = 7'h10;
    localparam logic [6:0] SegBlank = 7'h7F;

    localparam logic [2:0] DigHomeTens  = 3'd0;
    localparam logic [2:0] DigHomeUnits = 3'd1;
    localparam logic [2:0] DigAwayTens  = 3'd2;
    localparam logic [2:0] DigAwayUnits = 3'd3;
    localparam logic [2:0] DigShotTens  = 3'd4;
    localparam logic [2:0] DigShotUnits = 3'd5;

    // Double-dabble; inputs above 99 are outside the scoreboard range.
    function automatic logic [7:0] bin2bcd(input logic [6:0] bin);
        logic [14:0] sh;
        sh = {8'd0, bin};
        for (int i = 0; i < 7; i++) begin
            if (sh[10:7] >= 4'd5) sh[10:7] = sh[10:7] + 4'd3;
            if (sh[14:11] >= 4'd5) sh[14:11] = sh[14:11] + 4'd3;
            sh = sh << 1;
        end
        return sh[14:7];
    endfunction

endpackage

// File: rtl/placar_duplo_if.sv
// Board-side bundle of the scoreboard: debounced button/switch events in,
// scores, shot clock, buzzer and display pins out.
interface placar_duplo_if #(
    parameter int unsigned SCORE_W = 7
);
    logic               pts_valid;
    logic [1:0]         pts_val;
    logic               team;
    logic               sub;
    logic               shot_run;
    logic               shot_reload;
    logic               shot_sel;
    logic [SCORE_W-1:0] score_home;
    logic [SCORE_W-1:0] score_away;
    logic [6:0]         shot_cnt;
    logic [1:0]         shot_state;
    logic               sat_alert;
    logic               buzzer;
    logic [6:0]         seg;
    logic [5:0]         an;

    modport master (
        output pts_valid, pts_val, team, sub, shot_run, shot_reload, shot_sel,
        input  score_home, score_away, shot_cnt, shot_state, sat_alert, buzzer, seg, an
    );

    modport slave (
        input  pts_valid, pts_val, team, sub, shot_run, shot_reload, shot_sel,
        output score_home, score_away, shot_cnt, shot_state, sat_alert, buzzer, seg, an
    );
endinterface

// File: rtl/placar_varredura.sv
// Six-digit multiplexed 7-segment scanner: scan counter, digit mux, bin->BCD
// and segment decode, all outputs registered.
module placar_varredura
    import placar_pkg::*;
#(
    parameter int unsigned SCORE_W  = 7,
    parameter int unsigned SCAN_DIV = 65_536
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [SCORE_W-1:0] home_i,
    input  logic [SCORE_W-1:0] away_i,
    input  logic [6:0]         shot_i,
    output logic [6:0]         seg_o,
    output logic [5:0]         an_o
);
    localparam int unsigned      ScanW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);

    logic [ScanW-1:0] scan_q, scan_d;
    logic [2:0]       digit_q, digit_d;
    logic [6:0]       seg_q, seg_d;
    logic [5:0]       an_q, an_d;
    logic [7:0]       bcd_home, bcd_away, bcd_shot;
    logic [3:0]       nibble;

    function automatic logic [6:0] seg_encode(input logic [3:0] n);
        case (n)
            4'd0:    return Seg0;
            4'd1:    return Seg1;
            4'd2:    return Seg2;
            4'd3:    return Seg3;
            4'd4:    return Seg4;
            4'd5:    return Seg5;
            4'd6:    return Seg6;
            4'd7:    return Seg7;
            4'd8:    return Seg8;
            4'd9:    return Seg9;
            default: return SegBlank;
        endcase
    endfunction

    assign bcd_home = bin2bcd(7'(home_i));
    assign bcd_away = bin2bcd(7'(away_i));
    assign bcd_shot = bin2bcd(shot_i);

    always_comb begin
        scan_d  = scan_q + 1'b1;
        digit_d = digit_q;
        if (scan_q == ScanLast) begin
            scan_d  = '0;
            digit_d = (digit_q == DigShotUnits) ? DigHomeTens : digit_q + 3'd1;
        end
    end

    // Tens digits are always shown, so a leading zero displays as 0.
    always_comb begin
        case (digit_q)
            DigHomeTens:  nibble = bcd_home[7:4];
            DigHomeUnits: nibble = bcd_home[3:0];
            DigAwayTens:  nibble = bcd_away[7:4];
            DigAwayUnits: nibble = bcd_away[3:0];
            DigShotTens:  nibble = bcd_shot[7:4];
            DigShotUnits: nibble = bcd_shot[3:0];
            default:      nibble = 4'hF;
        endcase
        seg_d = seg_encode(nibble);
        an_d  = ~(6'b000001 << digit_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scan_q  <= '0;
            digit_q <= DigHomeTens;
            seg_q   <= SegBlank;
            an_q    <= 6'h3F;
        end else begin
            scan_q  <= scan_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg_o = seg_q;
    assign an_o  = an_q;

endmodule

// File: rtl/placar_duplo.sv
// Two-team scoreboard core: saturating home/away scores, shot clock FSM with
// buzzer. Display scanner is built only when PLACAR_DUPLO_DISPLAY_EN is defined.
module placar_duplo
    import placar_pkg::*;
#(
    parameter int unsigned SCORE_MAX   = 99,
    parameter int unsigned SCORE_W     = 7,
    parameter int unsigned SHOT_LONG   = 24,
    parameter int unsigned SHOT_SHORT  = 14,
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned BUZZ_CYCLES = 25_000_000,
    parameter int unsigned SCAN_DIV    = 65_536
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    placar_duplo_if.slave board_io
);
    localparam int unsigned        ScoreW1     = SCORE_W + 1;
    localparam logic [SCORE_W:0]   ScoreMaxExt = ScoreW1'(SCORE_MAX);
    localparam logic [6:0]         ShotLong7   = 7'(SHOT_LONG);
    localparam logic [6:0]         ShotShort7  = 7'(SHOT_SHORT);
    localparam int unsigned        PrescW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PrescW-1:0]  PrescLast   = PrescW'(TICK_DIV - 1);
    localparam int unsigned        BuzzW       = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
    localparam logic [BuzzW-1:0]   BuzzLoad    = BuzzW'(BUZZ_CYCLES - 1);

    logic [SCORE_W-1:0] home_q, home_d, away_q, away_d;
    logic               sat_q, sat_d;
    shot_state_e        state_q, state_d;
    logic [6:0]         cnt_q, cnt_d;
    logic [PrescW-1:0]  presc_q, presc_d;
    logic               exp_q;
    logic               buzz_q, buzz_d;
    logic [BuzzW-1:0]   bcnt_q, bcnt_d;

    logic [SCORE_W-1:0] cur, res;
    logic [SCORE_W:0]   cur_ext, pv_ext, sum, diff;
    logic               tick;

    // Score path: one event per cycle, applied to the selected team only.
    always_comb begin
        home_d  = home_q;
        away_d  = away_q;
        sat_d   = 1'b0;
        cur     = board_io.team ? away_q : home_q;
        cur_ext = {1'b0, cur};
        pv_ext  = {{(SCORE_W - 1){1'b0}}, board_io.pts_val};
        sum     = cur_ext + pv_ext;
        diff    = cur_ext - pv_ext;
        res     = cur;
        if (board_io.pts_valid && (board_io.pts_val != 2'd0)) begin
            if (!board_io.sub) begin
                if (sum > ScoreMaxExt) begin
                    res   = ScoreMaxExt[SCORE_W-1:0];
                    sat_d = 1'b1;
                end else begin
                    res = sum[SCORE_W-1:0];
                end
            end else if (cur_ext < pv_ext) begin
                res   = '0;
                sat_d = 1'b1;
            end else begin
                res = diff[SCORE_W-1:0];
            end
            if (board_io.team) away_d = res;
            else               home_d = res;
        end
    end

    // Prescaler only advances while actually counting, so a pause keeps its phase.
    assign tick = (state_q == StRun) && board_io.shot_run && (presc_q == PrescLast);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        presc_d = presc_q;
        if (board_io.shot_reload) begin
            cnt_d   = board_io.shot_sel ? ShotLong7 : ShotShort7;
            presc_d = '0;
            state_d = board_io.shot_run ? StRun : StPause;
        end else begin
            case (state_q)
                StPause: begin
                    if (board_io.shot_run) state_d = StRun;
                end
                StRun: begin
                    if (!board_io.shot_run) begin
                        state_d = StPause;
                    end else if (tick) begin
                        presc_d = '0;
                        if (cnt_q <= 7'd1) begin
                            cnt_d   = 7'd0;
                            state_d = StExpired;
                        end else begin
                            cnt_d = cnt_q - 7'd1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                StExpired: ;
                default: state_d = StPause;
            endcase
        end
    end

    // Buzzer starts the cycle after EXPIRED is entered; a reload cuts it short.
    always_comb begin
        buzz_d = buzz_q;
        bcnt_d = bcnt_q;
        if (board_io.shot_reload) begin
            buzz_d = 1'b0;
            bcnt_d = '0;
        end else if ((state_q == StExpired) && !exp_q) begin
            buzz_d = 1'b1;
            bcnt_d = BuzzLoad;
        end else if (buzz_q) begin
            if (bcnt_q == '0) buzz_d = 1'b0;
            else              bcnt_d = bcnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            home_q  <= '0;
            away_q  <= '0;
            sat_q   <= 1'b0;
            state_q <= StPause;
            cnt_q   <= ShotLong7;
            presc_q <= '0;
            exp_q   <= 1'b0;
            buzz_q  <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            home_q  <= home_d;
            away_q  <= away_d;
            sat_q   <= sat_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            exp_q   <= (state_q == StExpired);
            buzz_q  <= buzz_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign board_io.score_home = home_q;
    assign board_io.score_away = away_q;
    assign board_io.sat_alert  = sat_q;
    assign board_io.shot_cnt   = cnt_q;
    assign board_io.shot_state = state_q;
    assign board_io.buzzer     = buzz_q;

`ifdef PLACAR_DUPLO_DISPLAY_EN
    placar_varredura #(
        .SCORE_W  (SCORE_W),
        .SCAN_DIV (SCAN_DIV)
    ) u_varredura (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .home_i (home_q),
        .away_i (away_q),
        .shot_i (cnt_q),
        .seg_o  (board_io.seg),
        .an_o   (board_io.an)
    );
`else
    assign board_io.seg = SegBlank;
    assign board_io.an  = 6'h3F;
`endif

endmodule

// File: tb/tb_placar_duplo.sv
// Directed bench for placar_duplo with small dividers; display checks follow
// PLACAR_DUPLO_DISPLAY_EN.
module tb_placar_duplo;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    placar_duplo_if #(.SCORE_W(7)) board_if ();

    placar_duplo #(
        .SCORE_MAX   (99),
        .SCORE_W     (7),
        .SHOT_LONG   (24),
        .SHOT_SHORT  (14),
        .TICK_DIV    (4),
        .BUZZ_CYCLES (3),
        .SCAN_DIV    (2)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .board_io (board_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        repeat (n) step();
    endtask

    task automatic score_ev(input logic t, input logic s, input logic [1:0] v);
        board_if.pts_valid = 1'b1;
        board_if.team      = t;
        board_if.sub       = s;
        board_if.pts_val   = v;
        step();
        board_if.pts_valid = 1'b0;
        board_if.pts_val   = 2'd0;
    endtask

    // Steps until shot_state reaches st, returning the number of edges taken.
    task automatic wait_state(input logic [1:0] st, input int bound, output int n);
        n = 0;
        while (board_if.shot_state != st && n < bound) begin
            step();
            n++;
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check_eq({pfx, "_home"},  board_if.score_home, 0);
        check_eq({pfx, "_away"},  board_if.score_away, 0);
        check_eq({pfx, "_shot"},  board_if.shot_cnt, 24);
        check_eq({pfx, "_state"}, board_if.shot_state, 0);
        check_eq({pfx, "_sat"},   board_if.sat_alert, 0);
        check_eq({pfx, "_buzz"},  board_if.buzzer, 0);
        check_eq({pfx, "_seg"},   board_if.seg, 32'h7F);
        check_eq({pfx, "_an"},    board_if.an, 32'h3F);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [6:0]  seg_tbl [10];
        int          exp_dig [6];
        logic [5:0]  exp_an;
        logic [5:0]  prev_an;
        logic        found;

        seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        exp_dig = '{1, 2, 3, 5, 2, 4};
        n_checks = 0;
        n_fail   = 0;

        rst_n                = 1'b0;
        board_if.pts_valid   = 1'b0;
        board_if.pts_val     = 2'd0;
        board_if.team        = 1'b0;
        board_if.sub         = 1'b0;
        board_if.shot_run    = 1'b0;
        board_if.shot_reload = 1'b0;
        board_if.shot_sel    = 1'b0;
        step_n(2);
        check_reset_values("rst");
        rst_n = 1'b1;
        step();

        // Score saturation
        for (int i = 0; i < 33; i++) score_ev(1'b0, 1'b0, 2'd3);
        check_eq("home_99", board_if.score_home, 99);
        check_eq("home_99_nosat", board_if.sat_alert, 0);
        score_ev(1'b0, 1'b0, 2'd1);
        check_eq("home_clamp", board_if.score_home, 99);
        check_eq("home_clamp_sat", board_if.sat_alert, 1);
        check_eq("home_clamp_away", board_if.score_away, 0);
        step();
        check_eq("sat_one_cycle", board_if.sat_alert, 0);
        score_ev(1'b1, 1'b0, 2'd2);
        check_eq("away_2", board_if.score_away, 2);
        score_ev(1'b1, 1'b1, 2'd3);
        check_eq("away_floor", board_if.score_away, 0);
        check_eq("away_floor_sat", board_if.sat_alert, 1);
        score_ev(1'b1, 1'b0, 2'd0);
        check_eq("zero_pts_away", board_if.score_away, 0);
        check_eq("zero_pts_sat", board_if.sat_alert, 0);
        score_ev(1'b0, 1'b1, 2'd0);
        check_eq("zero_pts_home", board_if.score_home, 99);
        score_ev(1'b0, 1'b1, 2'd3);
        check_eq("home_sub3", board_if.score_home, 96);
        check_eq("home_sub3_sat", board_if.sat_alert, 0);

        // Shot clock: short reload, counting, pause keeps prescaler phase
        board_if.shot_sel    = 1'b0;
        board_if.shot_run    = 1'b1;
        board_if.shot_reload = 1'b1;
        step();
        board_if.shot_reload = 1'b0;
        check_eq("reload_short", board_if.shot_cnt, 14);
        check_eq("reload_run", board_if.shot_state, 1);
        step_n(3);
        check_eq("pre_tick", board_if.shot_cnt, 14);
        step();
        check_eq("tick1", board_if.shot_cnt, 13);
        step_n(4);
        check_eq("tick2", board_if.shot_cnt, 12);
        step();
        board_if.shot_run = 1'b0;
        step();
        check_eq("pause_state", board_if.shot_state, 0);
        step_n(10);
        check_eq("pause_frozen", board_if.shot_cnt, 12);
        board_if.shot_run = 1'b1;
        step();
        check_eq("resume_state", board_if.shot_state, 1);
        step_n(2);
        check_eq("resume_hold", board_if.shot_cnt, 12);
        step();
        check_eq("resume_phase", board_if.shot_cnt, 11);

        // Run down to expiry and buzzer pulse
        wait_state(2'd2, 100, n);
        check_eq("expire_edges", n, 44);
        check_eq("expire_cnt", board_if.shot_cnt, 0);
        check_eq("buzz_entry", board_if.buzzer, 0);
        step();
        check_eq("buzz_c1", board_if.buzzer, 1);
        step();
        check_eq("buzz_c2", board_if.buzzer, 1);
        step();
        check_eq("buzz_c3", board_if.buzzer, 1);
        step();
        check_eq("buzz_off", board_if.buzzer, 0);
        check_eq("expired_hold", board_if.shot_state, 2);
        board_if.shot_sel    = 1'b1;
        board_if.shot_reload = 1'b1;
        step();
        board_if.shot_reload = 1'b0;
        check_eq("reload_long", board_if.shot_cnt, 24);
        check_eq("reload_long_run", board_if.shot_state, 1);

        // Reload coinciding with a tick wins; prescaler restarts
        step_n(3);
        board_if.shot_sel    = 1'b0;
        board_if.shot_reload = 1'b1;
        step();
        board_if.shot_reload = 1'b0;
        check_eq("reload_vs_tick", board_if.shot_cnt, 14);
        step_n(3);
        check_eq("presc_cleared", board_if.shot_cnt, 14);

        // Reload during buzzer cuts it off
        wait_state(2'd2, 100, n);
        check_eq("expire2_edges", n, 53);
        step();
        check_eq("buzz2_on", board_if.buzzer, 1);
        board_if.shot_run    = 1'b0;
        board_if.shot_sel    = 1'b1;
        board_if.shot_reload = 1'b1;
        step();
        board_if.shot_reload = 1'b0;
        check_eq("buzz_cut", board_if.buzzer, 0);
        check_eq("cut_state", board_if.shot_state, 0);
        check_eq("cut_cnt", board_if.shot_cnt, 24);

        // Asynchronous reset mid-run
        board_if.shot_run    = 1'b1;
        board_if.shot_reload = 1'b1;
        step();
        board_if.shot_reload = 1'b0;
        score_ev(1'b1, 1'b0, 2'd3);
        step_n(5);
        check_eq("prerst_cnt", board_if.shot_cnt, 23);
        check_eq("prerst_away", board_if.score_away, 3);
        rst_n = 1'b0;
        #1;
        check_reset_values("arst");
        board_if.shot_run = 1'b0;
        #2;
        rst_n = 1'b1;
        step();

        // Display: home 12, away 35, shot 24
        for (int i = 0; i < 4; i++) score_ev(1'b0, 1'b0, 2'd3);
        for (int i = 0; i < 11; i++) score_ev(1'b1, 1'b0, 2'd3);
        score_ev(1'b1, 1'b0, 2'd2);
        check_eq("disp_home", board_if.score_home, 12);
        check_eq("disp_away", board_if.score_away, 35);
`ifdef PLACAR_DUPLO_DISPLAY_EN
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev_an = board_if.an;
            step();
            if (board_if.an == 6'b111110 && prev_an != 6'b111110) found = 1'b1;
        end
        check_eq("scan_align", found, 1);
        for (int d = 0; d < 6; d++) begin
            exp_an = ~(6'b000001 << d);
            for (int k = 0; k < 2; k++) begin
                check_eq($sformatf("an_d%0d_%0d", d, k), board_if.an, exp_an);
                check_eq($sformatf("seg_d%0d_%0d", d, k), board_if.seg, seg_tbl[exp_dig[d]]);
                step();
            end
        end
        check_eq("scan_wrap", board_if.an, 6'b111110);
`else
        step_n(5);
        check_eq("blank_seg", board_if.seg, 32'h7F);
        check_eq("blank_an", board_if.an, 32'h3F);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
